// File: rtl/led_ring_monitor.sv
// Observer for a rotating one-hot LED ring: tracks the lit position, flags skips, bad patterns
// and stalls. Define LED_RING_MONITOR_LAP_EN to build the lap counter.
module led_ring_monitor #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned TIMEOUT = 10000000,
   localparam int unsigned PW     = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] led_in,
   input  logic             clr,
   output logic [PW-1:0]    pos,
   output logic             valid,
   output logic             step_pulse,
   output logic             err_skip,
   output logic             err_onehot,
   output logic             stall,
   output logic [15:0]      lap_cnt
);

   typedef enum logic {StIdle, StLock} state_t;

   localparam logic [WIDTH-1:0] LedOne = WIDTH'(1);

   state_t           state;
   logic [WIDTH-1:0] led_q;
   logic             first_q;
   logic [31:0]      stall_cnt;
   logic [31:0]      cnt_inc;
   logic [PW-1:0]    idx;
   logic [PW-1:0]    pos_inc;
   logic             one_hot;
   logic             ev_step;
   logic             ev_skip;
   logic             ev_hold;
   logic             ev_bad;

   always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (led_q[i]) idx = idx | PW'(i);
      end
   end

   assign one_hot = (led_q != '0) && ((led_q & (led_q - LedOne)) == '0);
   // Power-of-two width, so the natural wrap of the adder is the mod-WIDTH step.
   assign pos_inc = pos + PW'(1);
   assign cnt_inc = (stall_cnt == '1) ? stall_cnt : stall_cnt + 32'd1;

   assign ev_hold = (state == StLock) && one_hot && (idx == pos);
   assign ev_step = (state == StLock) && one_hot && (idx == pos_inc);
   assign ev_skip = (state == StLock) && one_hot && (idx != pos) && (idx != pos_inc);
   // The zero pattern left in led_q by reset is not a real observation.
   assign ev_bad  = !one_hot && ((state == StLock) || !first_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= StIdle;
         led_q      <= '0;
         first_q    <= 1'b1;
         pos        <= '0;
         valid      <= 1'b0;
         step_pulse <= 1'b0;
         err_skip   <= 1'b0;
         err_onehot <= 1'b0;
         stall      <= 1'b0;
         stall_cnt  <= '0;
      end else begin
         led_q      <= led_in;
         first_q    <= 1'b0;
         step_pulse <= ev_step;
         if (one_hot) pos <= idx;
         err_skip   <= (err_skip & ~clr) | ev_skip;
         err_onehot <= (err_onehot & ~clr) | ev_bad;
         stall_cnt  <= (ev_hold && !clr) ? cnt_inc : '0;
         stall      <= ev_hold && !clr && (cnt_inc >= 32'(TIMEOUT - 1));
         case (state)
            StIdle: begin
               if (one_hot) begin
                  state <= StLock;
                  valid <= 1'b1;
               end
            end
            StLock: begin
               if (!one_hot) begin
                  state <= StIdle;
                  valid <= 1'b0;
               end
            end
            default: begin
               state <= StIdle;
               valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef LED_RING_MONITOR_LAP_EN
   logic        ev_wrap;
   logic [15:0] lap_q;

   assign ev_wrap = ev_step && (pos == PW'(WIDTH - 1));

   // A wrap coinciding with clr still counts, leaving the counter at one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lap_q <= '0;
      end else if (clr) begin
         lap_q <= ev_wrap ? 16'd1 : 16'd0;
      end else if (ev_wrap && (lap_q != 16'hFFFF)) begin
         lap_q <= lap_q + 16'd1;
      end
   end

   assign lap_cnt = lap_q;
`else
   assign lap_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_led_ring_monitor.sv
// Randomised bench for led_ring_monitor against an event-level model of the ring observer.
module tb_led_ring_monitor;

   localparam int W  = 16;
   localparam int TO = 8;
`ifdef LED_RING_MONITOR_LAP_EN
   localparam bit LapEn = 1'b1;
`else
   localparam bit LapEn = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [15:0] led_in;
   logic        clr;
   logic [3:0]  pos;
   logic        valid;
   logic        step_pulse;
   logic        err_skip;
   logic        err_onehot;
   logic        stall;
   logic [15:0] lap_cnt;

   led_ring_monitor #(
      .WIDTH   (W),
      .TIMEOUT (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .led_in     (led_in),
      .clr        (clr),
      .pos        (pos),
      .valid      (valid),
      .step_pulse (step_pulse),
      .err_skip   (err_skip),
      .err_onehot (err_onehot),
      .stall      (stall),
      .lap_cnt    (lap_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: the last sampled pattern plus what an observer would conclude from it.
   logic [15:0] m_ledq;
   bit          m_first;
   bit          m_lock;
   int          m_pos;
   bit          m_step;
   bit          m_eskip;
   bit          m_eoh;
   bit          m_stall;
   int          m_quiet;
   int          m_lap;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_ledq = '0; m_first = 1'b1; m_lock = 1'b0; m_pos = 0; m_step = 1'b0;
      m_eskip = 1'b0; m_eoh = 1'b0; m_stall = 1'b0; m_quiet = 0; m_lap = 0;
   endtask

   task automatic model_step(input logic [15:0] v, input logic c);
      bit oh, hold, step, wrap, skip, bad;
      int ix;
      oh = (m_ledq != 0) && ($countones(m_ledq) == 1);
      ix = $clog2(m_ledq);
      hold = 0; step = 0; wrap = 0; skip = 0; bad = 0;
      if (!m_lock) begin
         if (oh) begin m_lock = 1; m_pos = ix; end
         else if (!m_first) bad = 1;
      end else if (!oh) begin
         bad = 1; m_lock = 0;
      end else if (ix == m_pos) begin
         hold = 1;
      end else if (ix == (m_pos + 1) % W) begin
         step = 1; wrap = (m_pos == W - 1); m_pos = ix;
      end else begin
         skip = 1; m_pos = ix;
      end
      m_quiet = (hold && !c) ? m_quiet + 1 : 0;
      m_stall = (m_quiet >= TO - 1);
      if (c) begin m_eskip = 0; m_eoh = 0; m_lap = 0; end
      if (skip) m_eskip = 1;
      if (bad) m_eoh = 1;
      if (LapEn && wrap && m_lap < 65535) m_lap++;
      m_step = step;
      m_first = 0;
      m_ledq = v;
   endtask

   task automatic compare_all();
      chk("pos", int'(pos), m_pos);
      chk("valid", int'(valid), int'(m_lock));
      chk("step_pulse", int'(step_pulse), int'(m_step));
      chk("err_skip", int'(err_skip), int'(m_eskip));
      chk("err_onehot", int'(err_onehot), int'(m_eoh));
      chk("stall", int'(stall), int'(m_stall));
      chk("lap_cnt", int'(lap_cnt), m_lap);
   endtask

   task automatic tick(input logic [15:0] v, input logic c);
      led_in = v;
      clr = c;
      @(posedge clk);
      model_step(v, c);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      rst = 1'b1;
   endtask

   int steps;
   int rp;
   int r;
   logic [15:0] v;

   initial begin
      rst = 1'b0; led_in = '0; clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", int'(valid), 0);
      chk("rst_pos", int'(pos), 0);
      chk("rst_flags", int'({step_pulse, err_skip, err_onehot, stall}), 0);
      chk("rst_lap", int'(lap_cnt), 0);
      @(negedge clk);
      rst = 1'b1;

      // Lock and single step.
      tick(16'h0001, 0);
      chk("first_cycle_no_err", int'(err_onehot), 0);
      tick(16'h0001, 0);
      chk("lock_valid", int'(valid), 1);
      chk("lock_pos", int'(pos), 0);
      tick(16'h0001, 0);
      tick(16'h0002, 0);
      chk("step_not_early", int'(step_pulse), 0);
      tick(16'h0002, 0);
      chk("step_pulse_lit", int'(step_pulse), 1);
      chk("step_pos_lit", int'(pos), 1);
      chk("step_model_pos", m_pos, 1);
      tick(16'h0002, 0);
      chk("step_one_cycle", int'(step_pulse), 0);

      // Two full laps.
      steps = 0;
      for (int i = 2; i <= 33; i++) begin
         tick(16'(32'd1 << (i % 16)), 0);
         steps += int'(step_pulse);
      end
      tick(16'h0002, 0);
      steps += int'(step_pulse);
      chk("rotate_steps", steps, 32);
      chk("rotate_lap", int'(lap_cnt), LapEn ? 2 : 0);
      chk("rotate_model_lap", m_lap, LapEn ? 2 : 0);
      chk("rotate_no_err", int'({err_skip, err_onehot}), 0);

      // Reset mid-operation, then skip.
      do_reset();
      chk("midrst_valid", int'(valid), 0);
      tick(16'h0001, 0);
      tick(16'h0001, 0);
      tick(16'h0001, 0);
      chk("relock_no_err", int'(err_onehot), 0);
      tick(16'h0004, 0);
      tick(16'h0004, 0);
      chk("skip_err", int'(err_skip), 1);
      chk("skip_pos", int'(pos), 2);
      chk("skip_no_step", int'(step_pulse), 0);
      chk("skip_valid", int'(valid), 1);
      tick(16'h0008, 0);
      tick(16'h0008, 0);
      chk("after_skip_step", int'(step_pulse), 1);
      chk("after_skip_pos", int'(pos), 3);

      // Bad pattern, re-lock and clear.
      tick(16'h0003, 0);
      tick(16'h0003, 0);
      chk("bad_err", int'(err_onehot), 1);
      chk("bad_valid", int'(valid), 0);
      tick(16'h0010, 0);
      tick(16'h0010, 0);
      chk("relock_pos", int'(pos), 4);
      chk("relock_valid", int'(valid), 1);
      tick(16'h0010, 1);
      chk("clr_onehot", int'(err_onehot), 0);
      chk("clr_skip", int'(err_skip), 0);
      tick(16'h0040, 0);
      tick(16'h0040, 1);
      chk("clr_vs_skip", int'(err_skip), 1);
      chk("clr_vs_skip_model", int'(m_eskip), 1);

      // Stall: skip onto bit 5, then hold.
      tick(16'h0020, 0);
      tick(16'h0020, 0);
      repeat (6) tick(16'h0020, 0);
      chk("stall_not_yet", int'(stall), 0);
      tick(16'h0020, 0);
      chk("stall_set", int'(stall), 1);
      chk("stall_model", int'(m_stall), 1);
      tick(16'h0040, 0);
      chk("stall_held", int'(stall), 1);
      tick(16'h0040, 0);
      chk("stall_drop", int'(stall), 0);
      chk("stall_drop_step", int'(step_pulse), 1);

      // Randomised traffic.
      do_reset();
      rp = 0;
      for (int n = 0; n < 3000; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 55) begin
            rp = (rp + 1) % W;
            v = 16'(32'd1 << rp);
         end else if (r < 75) begin
            v = 16'(32'd1 << rp);
         end else if (r < 85) begin
            rp = int'($urandom_range(0, W - 1));
            v = 16'(32'd1 << rp);
         end else if (r < 91) begin
            v = 16'($urandom);
         end else if (r < 93) begin
            v = '0;
         end else begin
            v = 16'(32'd1 << rp);
            repeat (int'($urandom_range(8, 14))) tick(v, 0);
         end
         tick(v, ($urandom_range(0, 24) == 0));
         if ($urandom_range(0, 299) == 0) do_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
